// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage for one core. Owns the PC. Fetches from the shared
// instruction memory over a valid/ready request channel and an in-order
// response channel with at most one request outstanding. Drives the IF/ID
// pipeline register that decode reads.
//
//   pipeline_stall   : decode load-use hazard; hold IF/ID and freeze the PC.
//   ex_branch_taken  : redirect from EX; flush IF/ID, load the new PC and
//                      discard any fetch still in flight. Wins over a stall.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   pipeline_stall    hold request from decode
//   ex_branch_taken   redirect request from EX
//   ex_branch_target  redirect address (bits [1:0] ignored)
//   imem_req_*        fetch request channel (valid/ready, addr)
//   imem_resp_*       fetch response channel (valid, 32-bit instruction)
//   if_id_pc/instr/valid  IF/ID register contents (valid=0 means bubble)
//
// Optional feature: define FETCH_PERF_COUNTERS_EN to add the outputs
//   perf_fetched      words loaded into IF/ID (killed words excluded)
//   perf_stall_cycles cycles with pipeline_stall=1 and no redirect
// Both counters reset to 0 and wrap at 2^32.
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pipeline_stall,
  input  logic            ex_branch_taken,
  input  logic [XLEN-1:0] ex_branch_target,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr,
  output logic            if_id_valid
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall_cycles
`endif
);

  // S_REQ : request outstanding on the bus (not yet accepted)
  // S_WAIT: request accepted, waiting for the response
  // S_FULL: response captured in the skid buffer while decode is stalled
  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;

  localparam logic [31:0]     NOP     = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN   = ~XLEN'(3);

  logic [1:0]      state;
  logic [XLEN-1:0] pc;
  logic            kill;          // in-flight response must be dropped
  logic [XLEN-1:0] inflight_pc;   // address of the accepted request
  logic [XLEN-1:0] skid_pc;
  logic [31:0]     skid_instr;

  logic            handshake;
  logic            deliver;       // a word enters IF/ID at this edge
  logic [XLEN-1:0] deliver_pc;
  logic [31:0]     deliver_instr;
  logic [XLEN-1:0] redirect_pc;

  // Gated with rst_n so no request is presented during the reset cycle,
  // whatever state the FSM happens to be in.
  assign imem_req_valid = rst_n && (state == S_REQ);
  assign imem_req_addr  = pc;
  assign handshake      = imem_req_valid && imem_req_ready;
  assign redirect_pc    = ex_branch_target & ALIGN;

  // A word reaches IF/ID only when neither redirect nor stall blocks it.
  // Straight from the response in S_WAIT, or from the skid in S_FULL.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    deliver       = 1'b0;
    deliver_pc    = inflight_pc;
    deliver_instr = imem_resp_data;
    if (!ex_branch_taken && !pipeline_stall) begin
      if (state == S_WAIT && imem_resp_valid && !kill) begin
        deliver = 1'b1;
      end else if (state == S_FULL) begin
        deliver       = 1'b1;
        deliver_pc    = skid_pc;
        deliver_instr = skid_instr;
      end
    end
  end

  // Control state, PC and IF/ID.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    if (!rst_n) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      kill        <= 1'b0;
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_instr <= NOP;
    end else begin
      case (state)
        S_REQ: begin
          if (handshake) begin
            state <= S_WAIT;
            // A redirect in the same cycle as the handshake kills that fetch.
            kill  <= ex_branch_taken;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if (kill || ex_branch_taken) begin
              kill  <= 1'b0;
              state <= S_REQ;
            end else if (!pipeline_stall) begin
              state <= S_REQ;
            end else begin
              state <= S_FULL;
            end
          end else if (ex_branch_taken) begin
            kill <= 1'b1;
          end
        end
        S_FULL: begin
          // Leaving S_FULL empties the skid, whether by delivery or redirect.
          if (ex_branch_taken || !pipeline_stall) begin
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase

      if (ex_branch_taken) begin
        pc <= redirect_pc;
      end else if (deliver) begin
        pc <= deliver_pc + PC_STEP;
      end

      if (ex_branch_taken) begin
        if_id_valid <= 1'b0;
      end else if (pipeline_stall) begin
        if_id_valid <= if_id_valid;
      end else if (deliver) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= deliver_pc;
        if_id_instr <= deliver_instr;
      end else begin
        if_id_valid <= 1'b0;
      end
    end
  end

  // Payload registers. Their contents matter only while the FSM is in the
  // state that owns them, so they carry no reset.
  always_ff @(posedge clk) begin
    // NOTE: pure data registers are left out of reset; the control state that
    // qualifies them is reset, which is enough and keeps them plain flops.
    if (state == S_REQ && handshake) begin
      inflight_pc <= pc;
    end
    if (state == S_WAIT && imem_resp_valid && !kill && pipeline_stall) begin
      skid_pc    <= inflight_pc;
      skid_instr <= imem_resp_data;
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched      <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (deliver) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (pipeline_stall && !ex_branch_taken) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage for each core.
- Owns the PC and issues requests to the shared instruction memory over a valid/ready request channel and a valid response channel.
- Drives the IF/ID pipeline register consumed by decode.
- Honours pipeline_stall from decode's load-use detector: hold the IF/ID contents, freeze the PC. Honours branch/jump redirects from EX: flush the IF/ID contents, load the new PC, discard any in-flight fetch.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset (per-core boot address).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- pipeline_stall  in  1  from the decode hazard detector; hold IF/ID and PC.
- ex_branch_taken  in  1  redirect request from EX.
- ex_branch_target  in  XLEN  redirect address; bits [1:0] are forced to 0.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  XLEN  fetch address.
- imem_req_ready  in  1  request accepted when valid && ready.
- imem_resp_valid  in  1  response valid; responses are in order, at most 1 outstanding.
- imem_resp_data  in  32  instruction word.
- if_id_pc  out  XLEN  PC of the instruction held in IF/ID.
- if_id_instr  out  32  instruction held in IF/ID.
- if_id_valid  out  1  IF/ID holds a real instruction (0 = bubble).

Behaviour:
- Reset (rst_n=0 at posedge):
  - pc=RESET_PC, state=S_REQ, kill=0, skid empty.
  - if_id_valid=0, if_id_pc=0, if_id_instr=32'h0000_0013 (NOP).
  - imem_req_valid is 0 during the reset cycle.
  - Reset mid-transaction drops all state. A response arriving after reset while in S_REQ is ignored.
- FSM states S_REQ, S_WAIT, S_FULL:
  - S_REQ: imem_req_valid=1, imem_req_addr=pc. On valid&&ready, latch inflight_pc=pc and go to S_WAIT. The address may change while unaccepted; memory samples it only on the handshake.
  - S_WAIT: imem_req_valid=0. On resp_valid:
    - If kill=1: drop the word, clear kill, go to S_REQ.
    - Else if !pipeline_stall: load IF/ID with {inflight_pc, data, valid=1}, pc<=inflight_pc+4, go to S_REQ.
    - Else: store the word in the skid buffer, go to S_FULL.
  - S_FULL: imem_req_valid=0. When !pipeline_stall: move the skid entry to IF/ID, pc<=skid_pc+4, go to S_REQ.
- IF/ID update, priority high to low:
  1. Redirect: if_id_valid<=0.
  2. pipeline_stall: hold all IF/ID outputs.
  3. New word delivered: load it.
  4. Otherwise: if_id_valid<=0 (bubble); pc/instr hold their values.
- Redirect (ex_branch_taken=1) always wins over stall:
  - pc<=ex_branch_target & ~3.
  - Skid cleared.
  - S_FULL goes to S_REQ.
  - In S_WAIT with no response this cycle: set kill=1 and stay in S_WAIT.
  - In S_WAIT with a response the same cycle: drop the word and go to S_REQ.
  - In S_REQ with the handshake the same cycle: go to S_WAIT with kill=1.
  - In S_REQ with no handshake: the next request uses the target address.
- Latency: a fetch with ready=1 and 1-cycle memory yields one instruction every 2 cycles. IF/ID updates on the posedge where resp_valid is sampled.
- PC arithmetic is modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0.

Optional Feature:
- Macro FETCH_PERF_COUNTERS_EN.
- Defined: adds outputs perf_fetched (32) and perf_stall_cycles (32), both reset to 0.
  - perf_fetched increments on each word loaded into IF/ID (excluding killed words).
  - perf_stall_cycles increments on each cycle with pipeline_stall=1 and no redirect.
  - Both wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset with RESET_PC=32'h100, ready=1, 1-cycle memory returning addr-derived words -> if_id_pc sequence 0x100, 0x104, 0x108, with if_id_valid pulsing 1 every 2nd cycle.
- Stall held 3 cycles while a response arrives -> word captured in skid; IF/ID holds 0x104 unchanged; after the stall drops, IF/ID=0x108 next cycle; no request is issued during S_FULL.
- ex_branch_taken with target 32'h203 while in S_WAIT, response 2 cycles later -> that response is discarded; next imem_req_addr=0x200; if_id_valid=0 the cycle after the redirect.
- Redirect and stall asserted together in S_FULL -> skid dropped, if_id_valid=0, next request to the target.
- rst_n low for 1 cycle during S_WAIT -> all outputs return to reset values; the late response is ignored; the next request goes to RESET_PC.
- With FETCH_PERF_COUNTERS_EN, 10 fetches with 4 stall cycles and 1 killed fetch -> perf_fetched=9, perf_stall_cycles=4.
